// File: rtl/imul_issue_arb_pkg.sv
// Shared types and helpers for the IMUL issue arbiter.
package imul_arb_pkg;

   // Occupancy of the shared IMUL
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Pick the IMUL occupancy for an op from its word/doubleword flag
   function automatic int unsigned lat_sel(input logic        is_word,
                                           input int unsigned lat_w,
                                           input int unsigned lat_dw);
      return is_word ? lat_w : lat_dw;
   endfunction

endpackage

// File: rtl/imul_issue_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt
);

   logic found;

   // Scan distances 0..NUM_REQ-1 from ptr and grant the first requester
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i == ((32'(ptr) + k) % NUM_REQ))) begin
               gnt[i] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/imul_issue_arb.sv
// Issue arbiter sharing one IMUL between NUM_REQ scheduler ports.
// Optional feature: define IMUL_ARB_PERF_EN to add Perf_Issued / Perf_Stall counters.
module imul_issue_arb
   import imul_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned PAYLOAD_W   = 256,
   parameter int unsigned LAT_W       = 2,
   parameter int unsigned LAT_DW      = 2,
   parameter int unsigned SPEC_STATES = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           Flush,
   input  logic                           Kill_Enable,
   input  logic [SPEC_STATES-1:0]         Kill_VKillMask,
   input  logic [NUM_REQ-1:0]             Req_Valid,
   input  logic [NUM_REQ-1:0]             Req_IsWord,
   input  logic [NUM_REQ*SPEC_STATES-1:0] Req_KillMask,
   input  logic [NUM_REQ*PAYLOAD_W-1:0]   Req_Payload,
   output logic [NUM_REQ-1:0]             Req_Ready,
   output logic                           Mul_Valid,
   output logic [PAYLOAD_W-1:0]           Mul_Payload,
   output logic                           Mul_Done,
`ifdef IMUL_ARB_PERF_EN
   output logic [31:0]                    Perf_Issued,
   output logic [31:0]                    Perf_Stall,
`endif
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] Mul_ReqId
);

   localparam int unsigned RID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned LAT_MAX = (LAT_W > LAT_DW) ? LAT_W : LAT_DW;
   localparam int unsigned CNT_W   = $clog2(LAT_MAX) + 1;

   arb_state_e             state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [RID_W-1:0]       rr_ptr;
   logic [SPEC_STATES-1:0] inflight_mask;
   logic [NUM_REQ-1:0]     eligible, grant;
   logic                   kill_inflight, last_cyc, can_accept, accept;
   logic [RID_W-1:0]       gidx;
   logic [PAYLOAD_W-1:0]   sel_payload;
   logic [SPEC_STATES-1:0] sel_mask;
   logic                   sel_word;

   // A port competes only if it is valid and not being killed this cycle
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         eligible[i] = Req_Valid[i] &
                       ~(Kill_Enable & (|(Req_KillMask[i*SPEC_STATES +: SPEC_STATES] & Kill_VKillMask)));
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (RID_W)
   ) u_rr_arbiter (
      .req (eligible),
      .ptr (rr_ptr),
      .gnt (grant)
   );

   assign kill_inflight = (state == ST_BUSY) & Kill_Enable & (|(inflight_mask & Kill_VKillMask));
   assign last_cyc      = (state == ST_BUSY) & (cnt == CNT_W'(1));
   assign can_accept    = ~rst & ~Flush & ~kill_inflight & ((state == ST_IDLE) | last_cyc);
   assign accept        = |Req_Ready;

   // Steer the granted port's fields
   always_comb begin
      gidx        = '0;
      sel_payload = '0;
      sel_mask    = '0;
      sel_word    = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            gidx        = RID_W'(i);
            sel_payload = Req_Payload[i*PAYLOAD_W +: PAYLOAD_W];
            sel_mask    = Req_KillMask[i*SPEC_STATES +: SPEC_STATES];
            sel_word    = Req_IsWord[i];
         end
      end
   end

   // FSM state and occupancy counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: flush/kill drop the op, accept (re)loads, otherwise count down
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (Flush || kill_inflight) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else if (accept) begin
         state_nxt = ST_BUSY;
         cnt_nxt   = CNT_W'(lat_sel(sel_word, LAT_W, LAT_DW));
      end else if (state == ST_BUSY) begin
         cnt_nxt = cnt - CNT_W'(1);
         if (last_cyc) state_nxt = ST_IDLE;
      end
   end

   // Handshake and status outputs; all forced low while in reset
   always_comb begin
      Req_Ready = '0;
      Mul_Valid = 1'b0;
      Mul_Done  = 1'b0;
      if (can_accept) Req_Ready = grant;
      Mul_Valid = (state == ST_BUSY) & ~rst;
      Mul_Done  = last_cyc & ~kill_inflight & ~Flush & ~rst;
   end

   // Capture the granted op and advance the round-robin pointer past it
   always_ff @(posedge clk) begin
      if (rst) begin
         Mul_Payload   <= '0;
         Mul_ReqId     <= '0;
         inflight_mask <= '0;
         rr_ptr        <= '0;
      end else if (accept) begin
         Mul_Payload   <= sel_payload;
         Mul_ReqId     <= gidx;
         inflight_mask <= sel_mask;
         rr_ptr        <= (gidx == RID_W'(NUM_REQ - 1)) ? '0 : gidx + RID_W'(1);
      end
   end

`ifdef IMUL_ARB_PERF_EN
   // Issue and stall event counters, free-running with natural wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         Perf_Issued <= '0;
         Perf_Stall  <= '0;
      end else begin
         if (accept) Perf_Issued <= Perf_Issued + 32'd1;
         if ((|Req_Valid) && !accept) Perf_Stall <= Perf_Stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imul_issue_arb.sv
// Directed testbench for imul_issue_arb (default parameters, 2-cycle latency).
module tb_imul_issue_arb;

   localparam logic [255:0] P0 = {8{32'hA5A5_0000}};
   localparam logic [255:0] P1 = {8{32'h5A5A_1111}};

   logic         clk = 1'b0;
   logic         rst;
   logic         Flush;
   logic         Kill_Enable;
   logic [7:0]   Kill_VKillMask;
   logic [1:0]   Req_Valid;
   logic [1:0]   Req_IsWord;
   logic [15:0]  Req_KillMask;
   logic [511:0] Req_Payload;
   logic [1:0]   Req_Ready;
   logic         Mul_Valid;
   logic [255:0] Mul_Payload;
   logic         Mul_Done;
   logic [0:0]   Mul_ReqId;
`ifdef IMUL_ARB_PERF_EN
   logic [31:0]  Perf_Issued;
   logic [31:0]  Perf_Stall;
`endif

   int tests = 0;
   int fails = 0;

   imul_issue_arb dut (
      .clk            (clk),
      .rst            (rst),
      .Flush          (Flush),
      .Kill_Enable    (Kill_Enable),
      .Kill_VKillMask (Kill_VKillMask),
      .Req_Valid      (Req_Valid),
      .Req_IsWord     (Req_IsWord),
      .Req_KillMask   (Req_KillMask),
      .Req_Payload    (Req_Payload),
      .Req_Ready      (Req_Ready),
      .Mul_Valid      (Mul_Valid),
      .Mul_Payload    (Mul_Payload),
      .Mul_Done       (Mul_Done),
`ifdef IMUL_ARB_PERF_EN
      .Perf_Issued    (Perf_Issued),
      .Perf_Stall     (Perf_Stall),
`endif
      .Mul_ReqId      (Mul_ReqId)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   // Return to a clean idle state with rr_ptr = 0
   task automatic do_reset;
      rst = 1'b1; Flush = 1'b0; Kill_Enable = 1'b0; Kill_VKillMask = '0;
      Req_Valid = '0; Req_IsWord = '0; Req_KillMask = '0; Req_Payload = {P1, P0};
      cyc; cyc;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; Req_Valid = 2'b11;
      cyc; #2;
      tests++; if (Req_Ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b expected 00", Req_Ready); end
      tests++; if (Mul_Valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", Mul_Valid); end
      tests++; if (Mul_Done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", Mul_Done); end
      cyc; #2;
      tests++; if (Mul_Payload !== 256'd0) begin fails++; $display("FAIL reset_payload: got %h expected 0", Mul_Payload); end
      tests++; if (Mul_ReqId !== 1'b0) begin fails++; $display("FAIL reset_reqid: got %b expected 0", Mul_ReqId); end
      rst = 1'b0; Req_Valid = 2'b00;
      cyc; #2;
      tests++; if (Mul_Valid !== 1'b0) begin fails++; $display("FAIL reset_idle_after: got %b expected 0", Mul_Valid); end
   endtask

   task automatic test_single;
      do_reset;
      Req_Valid = 2'b01; #2;
      tests++; if (Req_Ready !== 2'b01) begin fails++; $display("FAIL single_ready: got %b expected 01", Req_Ready); end
      cyc;
      Req_Valid = 2'b00; Req_Payload = {P1, P1}; #2;
      tests++; if (Mul_Valid !== 1'b1) begin fails++; $display("FAIL single_valid1: got %b expected 1", Mul_Valid); end
      tests++; if (Mul_Done !== 1'b0) begin fails++; $display("FAIL single_done1: got %b expected 0", Mul_Done); end
      tests++; if (Mul_ReqId !== 1'b0) begin fails++; $display("FAIL single_reqid: got %b expected 0", Mul_ReqId); end
      tests++; if (Mul_Payload !== P0) begin fails++; $display("FAIL single_payload: got %h expected %h", Mul_Payload, P0); end
      cyc; #2;
      tests++; if (Mul_Valid !== 1'b1) begin fails++; $display("FAIL single_valid2: got %b expected 1", Mul_Valid); end
      tests++; if (Mul_Done !== 1'b1) begin fails++; $display("FAIL single_done2: got %b expected 1", Mul_Done); end
      tests++; if (Mul_Payload !== P0) begin fails++; $display("FAIL single_payload_held: got %h expected %h", Mul_Payload, P0); end
      cyc; #2;
      tests++; if (Mul_Valid !== 1'b0) begin fails++; $display("FAIL single_idle: got %b expected 0", Mul_Valid); end
      tests++; if (Mul_Done !== 1'b0) begin fails++; $display("FAIL single_done3: got %b expected 0", Mul_Done); end
      Req_Payload = {P1, P0};
   endtask

   task automatic test_back_to_back;
      logic [0:0] exp_id;
      logic [1:0] exp_rdy;
      do_reset;
      Req_Valid = 2'b11; #2;
      tests++; if (Req_Ready !== 2'b01) begin fails++; $display("FAIL b2b_first_ready: got %b expected 01", Req_Ready); end
      cyc;
      for (int j = 0; j < 4; j++) begin
         exp_id  = 1'(j % 2);
         exp_rdy = exp_id ? 2'b01 : 2'b10;
         #2;
         tests++; if (Mul_Valid !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d]: got %b expected 1", j, Mul_Valid); end
         tests++; if (Mul_ReqId !== exp_id) begin fails++; $display("FAIL b2b_reqid[%0d]: got %b expected %b", j, Mul_ReqId, exp_id); end
         tests++; if (Mul_Payload !== (exp_id ? P1 : P0)) begin fails++; $display("FAIL b2b_payload[%0d]: got %h", j, Mul_Payload); end
         tests++; if (Mul_Done !== 1'b0) begin fails++; $display("FAIL b2b_done_early[%0d]: got %b expected 0", j, Mul_Done); end
         tests++; if (Req_Ready !== 2'b00) begin fails++; $display("FAIL b2b_ready_busy[%0d]: got %b expected 00", j, Req_Ready); end
         cyc; #2;
         tests++; if (Mul_Done !== 1'b1) begin fails++; $display("FAIL b2b_done[%0d]: got %b expected 1", j, Mul_Done); end
         tests++; if (Req_Ready !== exp_rdy) begin fails++; $display("FAIL b2b_ready_last[%0d]: got %b expected %b", j, Req_Ready, exp_rdy); end
         cyc;
      end
      Req_Valid = 2'b00;
   endtask

   task automatic test_kill;
      do_reset;
      // Matching kill on first busy cycle
      Req_KillMask = {8'h00, 8'h04}; Req_Valid = 2'b01; #2;
      tests++; if (Req_Ready !== 2'b01) begin fails++; $display("FAIL kill_accept: got %b expected 01", Req_Ready); end
      cyc;
      Req_Valid = 2'b00; Kill_Enable = 1'b1; Kill_VKillMask = 8'h04; #2;
      tests++; if (Mul_Done !== 1'b0) begin fails++; $display("FAIL kill_done: got %b expected 0", Mul_Done); end
      cyc;
      Kill_Enable = 1'b0; #2;
      tests++; if (Mul_Valid !== 1'b0) begin fails++; $display("FAIL kill_idle: got %b expected 0", Mul_Valid); end
      // Non-matching kill leaves the op alone
      Req_Valid = 2'b01; #2;
      tests++; if (Req_Ready !== 2'b01) begin fails++; $display("FAIL kill_nm_accept: got %b expected 01", Req_Ready); end
      cyc;
      Req_Valid = 2'b00; Kill_Enable = 1'b1; Kill_VKillMask = 8'h02; #2;
      tests++; if (Mul_Valid !== 1'b1) begin fails++; $display("FAIL kill_nm_valid: got %b expected 1", Mul_Valid); end
      cyc; #2;
      tests++; if (Mul_Done !== 1'b1) begin fails++; $display("FAIL kill_nm_done: got %b expected 1", Mul_Done); end
      cyc;
      // Matching kill on the last cycle blocks a waiting port
      Kill_Enable = 1'b0; Req_Valid = 2'b01; #2;
      cyc;
      Req_Valid = 2'b00;
      cyc;
      Req_Valid = 2'b10; Kill_Enable = 1'b1; Kill_VKillMask = 8'h04; #2;
      tests++; if (Mul_Done !== 1'b0) begin fails++; $display("FAIL kill_last_done: got %b expected 0", Mul_Done); end
      tests++; if (Req_Ready !== 2'b00) begin fails++; $display("FAIL kill_last_ready: got %b expected 00", Req_Ready); end
      cyc;
      Req_Valid = 2'b00; Kill_Enable = 1'b0; #2;
      tests++; if (Mul_Valid !== 1'b0) begin fails++; $display("FAIL kill_last_idle: got %b expected 0", Mul_Valid); end
   endtask

   task automatic test_kill_eligibility;
      do_reset;
      Req_KillMask = {8'h00, 8'h01}; Req_Valid = 2'b11;
      Kill_Enable = 1'b1; Kill_VKillMask = 8'h01; #2;
      tests++; if (Req_Ready !== 2'b10) begin fails++; $display("FAIL elig_ready: got %b expected 10", Req_Ready); end
      cyc;
      Req_Valid = 2'b00; Kill_Enable = 1'b0; #2;
      tests++; if (Mul_ReqId !== 1'b1) begin fails++; $display("FAIL elig_reqid: got %b expected 1", Mul_ReqId); end
      tests++; if (Mul_Payload !== P1) begin fails++; $display("FAIL elig_payload: got %h expected %h", Mul_Payload, P1); end
   endtask

   task automatic test_flush_and_rst;
      do_reset;
      Req_Valid = 2'b01; #2;
      cyc;
      Req_Valid = 2'b00;
      cyc;
      Req_Valid = 2'b10; Flush = 1'b1; #2;
      tests++; if (Mul_Done !== 1'b0) begin fails++; $display("FAIL flush_done: got %b expected 0", Mul_Done); end
      tests++; if (Req_Ready !== 2'b00) begin fails++; $display("FAIL flush_ready: got %b expected 00", Req_Ready); end
      cyc;
      Flush = 1'b0; #2;
      tests++; if (Mul_Valid !== 1'b0) begin fails++; $display("FAIL flush_idle: got %b expected 0", Mul_Valid); end
      tests++; if (Req_Ready !== 2'b10) begin fails++; $display("FAIL flush_next_ready: got %b expected 10", Req_Ready); end
      cyc;
      Req_Valid = 2'b00;
      cyc;
      // Reset on the last busy cycle with both ports waiting
      rst = 1'b1; Req_Valid = 2'b11; #2;
      tests++; if (Mul_Done !== 1'b0) begin fails++; $display("FAIL rst_mid_done: got %b expected 0", Mul_Done); end
      tests++; if (Req_Ready !== 2'b00) begin fails++; $display("FAIL rst_mid_ready: got %b expected 00", Req_Ready); end
      tests++; if (Mul_Valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", Mul_Valid); end
      cyc;
      rst = 1'b0; Req_Valid = 2'b00; #2;
      tests++; if (Mul_Valid !== 1'b0) begin fails++; $display("FAIL rst_after_valid: got %b expected 0", Mul_Valid); end
      tests++; if (Mul_Done !== 1'b0) begin fails++; $display("FAIL rst_after_done: got %b expected 0", Mul_Done); end
      tests++; if (Mul_ReqId !== 1'b0) begin fails++; $display("FAIL rst_after_reqid: got %b expected 0", Mul_ReqId); end
      tests++; if (Mul_Payload !== 256'd0) begin fails++; $display("FAIL rst_after_payload: got %h expected 0", Mul_Payload); end
   endtask

`ifdef IMUL_ARB_PERF_EN
   task automatic test_perf;
      do_reset;
      Req_Valid = 2'b01;
      for (int j = 0; j < 5; j++) cyc;
      Req_Valid = 2'b00; #2;
      tests++; if (Perf_Issued !== 32'd3) begin fails++; $display("FAIL perf_issued: got %0d expected 3", Perf_Issued); end
      tests++; if (Perf_Stall !== 32'd2) begin fails++; $display("FAIL perf_stall: got %0d expected 2", Perf_Stall); end
   endtask
`endif

   // Hard stop if the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; Flush = 1'b0; Kill_Enable = 1'b0; Kill_VKillMask = '0;
      Req_Valid = '0; Req_IsWord = '0; Req_KillMask = '0; Req_Payload = {P1, P0};
      test_reset;
      test_single;
      test_back_to_back;
      test_kill;
      test_kill_eligibility;
      test_flush_and_rst;
`ifdef IMUL_ARB_PERF_EN
      test_perf;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imul_issue_arb.md
IMUL_ISSUE_ARB -- requirements
Module: imul_issue_arb

Interface
REQ-001 Parameter NUM_REQ, default 2: number of scheduler ports sharing one IMUL.
REQ-002 Parameter PAYLOAD_W, default 256: width of the per-request S2E payload, passed through opaquely.
REQ-003 Parameter LAT_W, default 2: IMUL cycles for word ops.
REQ-004 Parameter LAT_DW, default 2: IMUL cycles for doubleword ops.
REQ-005 Parameter SPEC_STATES, default 8: kill-mask width.
REQ-006 clk  in  1  sole clock; all state updates on posedge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 Flush  in  1  pipeline flush; drops in-flight op.
REQ-009 Kill_Enable  in  1  branch-mispredict kill strobe.
REQ-010 Kill_VKillMask  in  SPEC_STATES  mispredicted-branch mask.
REQ-011 Req_Valid  in  NUM_REQ  per-port request valid.
REQ-012 Req_IsWord  in  NUM_REQ  per-port word-op flag; selects LAT_W vs LAT_DW.
REQ-013 Req_KillMask  in  NUM_REQ*SPEC_STATES  per-port branch dependency mask.
REQ-014 Req_Payload  in  NUM_REQ*PAYLOAD_W  per-port S2E payload.
REQ-015 Req_Ready  out  NUM_REQ  one-hot grant; request i accepted when Req_Valid[i]&Req_Ready[i].
REQ-016 Mul_Valid  out  1  IMUL port valid; high while op occupies IMUL.
REQ-017 Mul_Payload  out  PAYLOAD_W  registered payload of granted request.
REQ-018 Mul_Done  out  1  completion strobe; downstream captures IMUL result/wakeup this cycle.
REQ-019 Mul_ReqId  out  clog2(NUM_REQ) (min 1)  port index of in-flight op.

Function
REQ-020 FSM states IDLE, BUSY; a down-counter holds remaining cycles (width clog2(max(LAT_W,LAT_DW))+1).
REQ-021 Req_Ready is combinational: at most one bit set; set only if state is IDLE, or BUSY with counter==1 (last cycle), and no Flush, no kill of in-flight op.
REQ-022 Arbitration: round-robin over eligible ports starting at pointer rr_ptr; port eligible iff Req_Valid[i] and not (Kill_Enable & |(Req_KillMask[i] & Kill_VKillMask)).
REQ-023 On accept of port g: Mul_Payload, Mul_ReqId, in-flight kill mask captured; counter loaded with LAT_W or LAT_DW per Req_IsWord[g]; state BUSY; rr_ptr <= (g+1) mod NUM_REQ.
REQ-024 rr_ptr unchanged when no accept.
REQ-025 Mul_Valid = (state==BUSY); counter decrements each BUSY cycle.
REQ-026 Mul_Done = BUSY & counter==1 & not killed & not Flush; first Mul_Done exactly LAT cycles after the accept edge (LAT=1 gives Done in first BUSY cycle).
REQ-027 At counter==1 with no new accept: next state IDLE; with accept: stays BUSY (back-to-back, zero bubble).
REQ-028 Kill: if Kill_Enable & |(inflight_mask & Kill_VKillMask) in BUSY: Mul_Done=0, no accept this cycle, next state IDLE.
REQ-029 Kill_Enable with non-matching mask: in-flight op unaffected.
REQ-030 Flush in any state: Req_Ready=0, Mul_Done=0, next state IDLE, rr_ptr held.
REQ-031 Simultaneous Flush and kill: Flush behaviour applies.
REQ-032 Payload inputs of non-granted ports ignored; granted payload not re-sampled after accept.

Reset
REQ-033 rst (sync) forces state IDLE, counter 0, rr_ptr 0, Mul_Payload 0, Mul_ReqId 0, inflight mask 0.
REQ-034 During and in cycle of rst: Req_Ready=0, Mul_Valid=0, Mul_Done=0; rst mid-operation discards op with no Done.

Configuration
REQ-035 Macro IMUL_ARB_PERF_EN defined: adds outputs Perf_Issued (32b, increments per accept) and Perf_Stall (32b, increments each cycle with any Req_Valid but no accept); both cleared by rst, wrap at 2^32.
REQ-036 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-037 Shared package imul_arb_pkg holds FSM state enum and the latency-select helper function.
REQ-038 One sub-module rr_arbiter (NUM_REQ-wide request vector, pointer in, one-hot grant out, combinational); FSM/counter in top.

Verification
REQ-039 LAT_DW=2, port0 single DW request -> Req_Ready[0] one cycle, Mul_Valid 2 cycles, Mul_Done in 2nd, Mul_ReqId=0.
REQ-040 Both ports valid continuously, rr_ptr=0 -> grants alternate 0,1,0,1 back-to-back, Mul_Done every 2 cycles, no bubbles.
REQ-041 In-flight mask 8'h04, Kill_Enable with VKillMask 8'h04 in 1st BUSY cycle -> no Mul_Done, IDLE next; VKillMask 8'h02 -> Done unaffected.
REQ-042 Port0 valid with mask 8'h01, port1 valid, kill VKillMask 8'h01 in IDLE -> port1 granted, port0 not.
REQ-043 Flush on last BUSY cycle with port1 valid -> Mul_Done=0, no grant, IDLE next; rst mid-op -> all outputs 0 next cycle.
REQ-044 IMUL_ARB_PERF_EN: 3 accepts plus 2 stalled cycles -> Perf_Issued=3, Perf_Stall=2.
